// File: rtl/inst_encoder.sv
// -----------------------------------------------------------------------------
// inst_encoder
//
// Streaming RV32I instruction encoder. Takes decoded instruction fields over a
// valid/ready handshake, packs them into a 32-bit instruction word according
// to the format code, and queues the result in a small circular output FIFO
// with its own valid/ready handshake.
//
// Parameters:
//   DEPTH        output FIFO entries (supported: 2, 4)
//
// Ports:
//   clk_i        clock
//   rst_i        synchronous active-high reset
//   in_valid_i   input fields valid
//   in_ready_o   encoder can accept (registered state only, no fall-through)
//   fmt_i        format: 0=R 1=I 2=S 3=B 4=U 5=J, 6/7 reserved
//   opcode_i     opcode
//   rd_i         destination register
//   rs1_i        source register 1
//   rs2_i        source register 2
//   funct3_i     funct3
//   funct7_i     funct7 (R format only)
//   imm_i        architectural immediate (byte offset / value, not pre-shifted)
//   out_valid_o  encoded word available
//   out_ready_i  consumer accepts
//   out_inst_o   head-of-FIFO instruction word (0 when empty)
//   enc_count_o  words enqueued since reset (wraps)
//   err_o        one-cycle pulse after a rejected input
//
// Build option:
//   INST_ENCODER_RANGE_CHECK_EN  when defined, each accepted input has its
//   immediate/format checked; failing inputs are consumed but not enqueued and
//   err_o pulses. When undefined, immediates are silently truncated, reserved
//   formats encode as R, and err_o is tied 0.
// -----------------------------------------------------------------------------
module inst_encoder #(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [2:0]  fmt_i,
    input  logic [6:0]  opcode_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [2:0]  funct3_i,
    input  logic [6:0]  funct7_i,
    input  logic [31:0] imm_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_inst_o,
    output logic [15:0] enc_count_o,
    output logic        err_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    typedef enum logic [2:0] {
        FmtR   = 3'd0,
        FmtI   = 3'd1,
        FmtS   = 3'd2,
        FmtB   = 3'd3,
        FmtU   = 3'd4,
        FmtJ   = 3'd5,
        FmtRs6 = 3'd6,
        FmtRs7 = 3'd7
    } fmt_e;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [31:0]      r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic [15:0]      r_enc_count;

    // -------------------------------------------------------------------------
    // Combinational signals
    // -------------------------------------------------------------------------
    fmt_e        w_fmt;
    logic [31:0] w_word;
    logic        w_fields_ok;
    logic        w_accept;
    logic        w_push;
    logic        w_pop;

    assign w_fmt = fmt_e'(fmt_i);

    // -------------------------------------------------------------------------
    // Field packing
    // -------------------------------------------------------------------------
    always_comb begin
        w_word = '0;
        case (w_fmt)
            FmtI: begin
                w_word = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
            end
            FmtS: begin
                w_word = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
            end
            FmtB: begin
                // imm[0] is implied zero for branch offsets and is dropped
                w_word = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                          imm_i[4:1], imm_i[11], opcode_i};
            end
            FmtU: begin
                w_word = {imm_i[31:12], rd_i, opcode_i};
            end
            FmtJ: begin
                w_word = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
            end
            default: begin
                // R, and reserved codes when they are not rejected
                w_word = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Optional immediate / format range check
    // -------------------------------------------------------------------------
`ifdef INST_ENCODER_RANGE_CHECK_EN
    logic w_reject;
    logic r_err;

    always_comb begin
        w_fields_ok = 1'b1;
        case (w_fmt)
            FmtR: begin
                w_fields_ok = 1'b1;
            end
            FmtI, FmtS: begin
                // 12-bit signed immediate: bits 31..11 must be a sign extension
                w_fields_ok = (imm_i[31:11] == '0) || (imm_i[31:11] == '1);
            end
            FmtB: begin
                w_fields_ok = ((imm_i[31:12] == '0) || (imm_i[31:12] == '1)) && !imm_i[0];
            end
            FmtJ: begin
                w_fields_ok = ((imm_i[31:20] == '0) || (imm_i[31:20] == '1)) && !imm_i[0];
            end
            FmtU: begin
                w_fields_ok = (imm_i[11:0] == '0);
            end
            default: begin
                w_fields_ok = 1'b0;
            end
        endcase
    end

    assign w_reject = w_accept && !w_fields_ok;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_reject;
        end
    end

    assign err_o = r_err;
`else
    assign w_fields_ok = 1'b1;
    assign err_o       = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Handshakes
    // -------------------------------------------------------------------------
    // Readiness depends only on registered occupancy, never on out_ready_i.
    assign in_ready_o  = !rst_i && (r_count < CNT_FULL);
    assign out_valid_o = (r_count != '0);

    assign w_accept = in_valid_i && in_ready_o;
    assign w_push   = w_accept && w_fields_ok;
    assign w_pop    = out_valid_o && out_ready_i;

    assign out_inst_o  = out_valid_o ? r_mem[r_rptr] : 32'h0;
    assign enc_count_o = r_enc_count;

    // -------------------------------------------------------------------------
    // FIFO storage (contents need no reset: occupancy gates visibility)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_word;
        end
    end

    // -------------------------------------------------------------------------
    // FIFO pointers, occupancy, enqueue counter
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_enc_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr      <= (r_wptr == PTR_LAST) ? '0 : r_wptr + 1'b1;
                r_enc_count <= r_enc_count + 16'd1;
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == PTR_LAST) ? '0 : r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
